// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flash_arbiter
// Description : Two-port round-robin arbiter in front of a flash engine.
//               Port 0 (instruction) issues reads only; port 1 (data) issues
//               reads or word programs. One transaction is outstanding at a
//               time, guarded by a cycle watchdog that forces completion with
//               err set if the engine never finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_arbiter #(
    parameter logic [11:0] IDLE_STATE = 12'h001,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic [23:0] p0_addr,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_write,
    input  logic [23:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        flash_en,
    output logic        flash_write,
    output logic [23:0] flash_addr,
    output logic [31:0] flash_data_in,
    input  logic [31:0] flash_data_out,
    input  logic [11:0] state_to_cpu
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Watchdog value seen during the last permitted LAUNCH/BUSY cycle.
    localparam logic [31:0] C_WDOG_LAST = 32'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        w_to_err;

    logic        r_port;       // port owning the current transaction
    logic        r_last;       // port granted most recently (1 = port 1)
    logic        r_write;
    logic [23:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_wdog;

    logic        w_engine_idle;
    logic        w_grant_p1;
    logic        w_start;
    logic        w_timeout;
    logic [23:0] w_sel_addr;

    assign w_engine_idle = (state_to_cpu == IDLE_STATE);
    // With both ports asking, the one not served last wins.
    assign w_grant_p1    = p1_req & (~p0_req | ~r_last);
    assign w_start       = (r_state == S_IDLE) & (p0_req | p1_req) & w_engine_idle;
    assign w_timeout     = (r_wdog >= C_WDOG_LAST);
    assign w_sel_addr    = (w_grant_p1 ? p1_addr : p0_addr) & 24'hFF_FFFC;

    // State register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; a stuck engine is abandoned with err raised.
    always_comb begin
        w_next   = r_state;
        w_to_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (w_timeout) begin
                    w_next   = S_DONE;
                    w_to_err = 1'b1;
                end else if (!w_engine_idle) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_engine_idle) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next   = S_DONE;
                    w_to_err = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Transaction capture, read data, watchdog and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_write <= 1'b0;
            r_addr  <= 24'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
            r_wdog  <= 32'h0;
        end else begin
            if (w_start) begin
                r_port  <= w_grant_p1;
                r_last  <= w_grant_p1;
                r_write <= w_grant_p1 & p1_write;
                r_addr  <= w_sel_addr;
                r_wdata <= w_grant_p1 ? p1_wdata : 32'h0;
            end
            if ((r_state == S_BUSY) && w_engine_idle && !r_write) begin
                r_rdata <= flash_data_out;
            end
            if ((r_state == S_LAUNCH) || (r_state == S_BUSY)) begin
                r_wdog <= r_wdog + 32'd1;
            end else begin
                r_wdog <= 32'h0;
            end
            r_err <= w_to_err;
        end
    end

    assign flash_en      = (r_state == S_LAUNCH);
    assign flash_write   = r_write;
    assign flash_addr    = r_addr;
    assign flash_data_in = r_wdata;
    assign p0_ack        = (r_state == S_DONE) & ~r_port;
    assign p1_ack        = (r_state == S_DONE) & r_port;
    assign rdata         = r_rdata;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_arbiter
// Description : Self-checking bench for flash_arbiter with a behavioural flash
//               engine and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_arbiter;

    localparam logic [11:0] C_IDLE = 12'h001;
    localparam int          C_TO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p1_req = 1'b0, p1_write = 1'b0;
    logic [23:0] p0_addr = 24'h0, p1_addr = 24'h0;
    logic [31:0] p1_wdata = 32'h0;
    logic        p0_ack, p1_ack, err, flash_en, flash_write;
    logic [31:0] rdata, flash_data_in, flash_data_out;
    logic [23:0] flash_addr;
    logic [11:0] state_to_cpu;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    flash_arbiter #(.IDLE_STATE(C_IDLE), .TIMEOUT(C_TO)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack),
        .rdata(rdata), .err(err),
        .flash_en(flash_en), .flash_write(flash_write), .flash_addr(flash_addr),
        .flash_data_in(flash_data_in), .flash_data_out(flash_data_out),
        .state_to_cpu(state_to_cpu)
    );

    // ---------------- behavioural flash engine ----------------
    // eng_mode: 0 = normal, 1 = hangs busy, 2 = ignores flash_en
    logic        eng_busy = 1'b0;
    int          eng_cnt = 0;
    int          eng_lat = 1;
    int          eng_mode = 0;
    int          eng_starts = 0;
    logic [31:0] eng_dout = 32'h0;
    logic [23:0] cap_addr = 24'h0;
    logic        cap_write = 1'b0;
    logic [31:0] cap_data = 32'h0;
    logic [31:0] emem [logic [21:0]];

    function automatic logic [31:0] dflt(input logic [21:0] w);
        return {w[9:0], w} ^ 32'hC3A5_0F1E;
    endfunction

    assign state_to_cpu   = eng_busy ? 12'h002 : C_IDLE;
    assign flash_data_out = eng_dout;

    // Engine: accepts a start while idle, stays busy eng_lat cycles.
    always @(posedge clk) begin
        if (eng_busy) begin
            if (eng_mode != 1) begin
                if (eng_cnt <= 1) begin
                    eng_busy <= 1'b0;
                    if (cap_write) eng_dout <= $urandom;
                    else eng_dout <= emem.exists(cap_addr[23:2]) ? emem[cap_addr[23:2]] : dflt(cap_addr[23:2]);
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end else if (flash_en && eng_mode != 2) begin
            eng_busy   <= 1'b1;
            eng_cnt    <= eng_lat;
            cap_addr   <= flash_addr;
            cap_write  <= flash_write;
            cap_data   <= flash_data_in;
            eng_starts <= eng_starts + 1;
            if (flash_write) emem[flash_addr[23:2]] = flash_data_in;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] shadow [logic [21:0]];
    int          last_port = 1;
    logic [31:0] exp_rdata = 32'h0;

    function automatic logic [31:0] lookup(input logic [21:0] w);
        return shadow.exists(w) ? shadow[w] : dflt(w);
    endfunction

    function automatic logic [23:0] rand_addr();
        logic [23:0] r;
        r = 24'($urandom);
        if ($urandom_range(0, 1) == 1) r[23:5] = 19'd3;
        return r;
    endfunction

    task automatic wait_quiet();
        int b = 0;
        @(negedge clk);
        while (state_to_cpu != C_IDLE && b < 50) begin @(negedge clk); b++; end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_port = 1;
        exp_rdata = 32'h0;
        vectors++; if (flash_en !== 1'b0) begin miscompares++; $display("FAIL rst_flash_en got %b want 0", flash_en); end
        vectors++; if (flash_write !== 1'b0) begin miscompares++; $display("FAIL rst_flash_write got %b want 0", flash_write); end
        vectors++; if ({p0_ack, p1_ack} !== 2'b00) begin miscompares++; $display("FAIL rst_acks got %b want 00", {p0_ack, p1_ack}); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
        vectors++; if (flash_addr !== 24'h0) begin miscompares++; $display("FAIL rst_flash_addr got %h want 0", flash_addr); end
        vectors++; if (flash_data_in !== 32'h0) begin miscompares++; $display("FAIL rst_flash_data_in got %h want 0", flash_data_in); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", rdata); end
    endtask

    // One directed transaction on one port; lat = negedges from req to ack.
    task automatic single(input bit port, input bit wr, input logic [23:0] addr,
                          input logic [31:0] wd, output int lat);
        bit got;
        @(negedge clk);
        if (port) begin p1_addr = addr; p1_write = wr; p1_wdata = wd; p1_req = 1'b1; end
        else begin p0_addr = addr; p0_req = 1'b1; end
        lat = 0;
        while (!(p0_ack || p1_ack) && lat < 100) begin @(negedge clk); lat++; end
        got = port ? p1_ack : p0_ack;
        vectors++; if (got !== 1'b1 || (p0_ack && p1_ack)) begin miscompares++; $display("FAIL single_ack port%0d got %b%b want ack on own port", port, p0_ack, p1_ack); end
        last_port = port;
        if (port && wr) shadow[addr[23:2]] = wd;
        else exp_rdata = lookup(addr[23:2]);
        vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL single_rdata got %h want %h", rdata, exp_rdata); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL single_err got %b want 0", err); end
        vectors++; if (cap_addr !== {addr[23:2], 2'b00} || flash_addr !== {addr[23:2], 2'b00}) begin miscompares++; $display("FAIL single_addr got %h/%h want %h", cap_addr, flash_addr, {addr[23:2], 2'b00}); end
        vectors++; if (cap_write !== (port & wr)) begin miscompares++; $display("FAIL single_write got %b want %b", cap_write, port & wr); end
        if (port && wr) begin
            vectors++; if (cap_data !== wd) begin miscompares++; $display("FAIL single_wdata got %h want %h", cap_data, wd); end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        vectors++; if ({p0_ack, p1_ack, err} !== 3'b000) begin miscompares++; $display("FAIL single_pulse got ack/err %b want 000", {p0_ack, p1_ack, err}); end
    endtask

    task automatic test_latency();
        int lat;
        wait_quiet();
        eng_lat = 1;
        single(1'b0, 1'b0, rand_addr(), 32'h0, lat);
        vectors++; if (lat != 4) begin miscompares++; $display("FAIL min_latency got %0d want 4", lat); end
    endtask

    task automatic test_read_deadbeef();
        int lat;
        wait_quiet();
        eng_lat = 2;
        single(1'b1, 1'b1, 24'h000100, 32'hDEADBEEF, lat);
        wait_quiet();
        eng_lat = 3;
        single(1'b0, 1'b0, 24'h000103, 32'h0, lat);
        vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL p0_read got %h want deadbeef", rdata); end
    endtask

    task automatic test_write();
        int lat;
        wait_quiet();
        eng_lat = 2;
        single(1'b1, 1'b1, 24'h00F004, 32'h12345678, lat);
    endtask

    // Randomised contention: port k issues n[k] back-to-back ops holding req.
    task automatic run_reqs(input int n0_in, input int n1_in);
        int n[2];
        logic [23:0] a[2];
        int budget;
        bit stable, prev_ack;
        n[0] = n0_in; n[1] = n1_in;
        wait_quiet();
        if (n[0] > 0) begin a[0] = rand_addr(); p0_addr = a[0]; p0_req = 1'b1; end
        if (n[1] > 0) begin a[1] = rand_addr(); p1_addr = a[1]; p1_write = 1'($urandom); p1_wdata = $urandom; p1_req = 1'b1; end
        budget = 0; stable = 1'b1; prev_ack = 1'b0;
        while ((n[0] > 0 || n[1] > 0) && budget < 300) begin
            @(negedge clk); budget++;
            if (eng_busy || p0_ack || p1_ack) begin
                if (flash_addr !== cap_addr || flash_write !== cap_write || flash_data_in !== cap_data) stable = 1'b0;
            end
            if (p0_ack || p1_ack) begin
                int k, ek;
                bit wr;
                k  = p1_ack ? 1 : 0;
                ek = (n[0] > 0 && n[1] > 0) ? (last_port == 1 ? 0 : 1) : (n[0] > 0 ? 0 : 1);
                vectors++; if ((p0_ack && p1_ack) || k != ek || prev_ack) begin miscompares++; $display("FAIL rr_order got port%0d (both=%b prev=%b) want port%0d", k, p0_ack && p1_ack, prev_ack, ek); end
                last_port = k;
                wr = (k == 1) && p1_write;
                if (wr) shadow[a[1][23:2]] = p1_wdata;
                else exp_rdata = lookup(a[k][23:2]);
                vectors++; if (rdata !== exp_rdata || err !== 1'b0) begin miscompares++; $display("FAIL rr_rdata got %h err %b want %h err 0", rdata, err, exp_rdata); end
                vectors++; if (cap_addr !== {a[k][23:2], 2'b00} || cap_write !== wr || (wr && cap_data !== p1_wdata)) begin miscompares++; $display("FAIL rr_engine_op got %h/%b/%h want %h/%b", cap_addr, cap_write, cap_data, {a[k][23:2], 2'b00}, wr); end
                vectors++; if (!stable) begin miscompares++; $display("FAIL rr_stable got unstable engine inputs want stable"); end
                stable = 1'b1;
                if (n[k] > 0) n[k]--;
                if (k == 0) begin
                    if (n[0] == 0) p0_req = 1'b0; else begin a[0] = rand_addr(); p0_addr = a[0]; end
                end else begin
                    if (n[1] == 0) p1_req = 1'b0; else begin a[1] = rand_addr(); p1_addr = a[1]; p1_write = 1'($urandom); p1_wdata = $urandom; end
                end
                prev_ack = 1'b1;
            end else begin
                prev_ack = 1'b0;
            end
        end
        vectors++; if (n[0] != 0 || n[1] != 0) begin miscompares++; $display("FAIL rr_budget got %0d/%0d outstanding want 0/0", n[0], n[1]); end
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        vectors++; if ({p0_ack, p1_ack} !== 2'b00) begin miscompares++; $display("FAIL rr_pulse got %b want 00", {p0_ack, p1_ack}); end
    endtask

    task automatic test_back_to_back();
        test_reset();
        eng_lat = 2;
        run_reqs(2, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int a0, a1;
            a0 = $urandom_range(0, 3);
            a1 = $urandom_range(0, 3);
            if (a0 == 0 && a1 == 0) a0 = 1;
            eng_lat = $urandom_range(1, 4);
            run_reqs(a0, a1);
        end
    endtask

    // mode 1: engine hangs busy; mode 2: engine never leaves idle.
    task automatic test_timeout(input int mode, input bit port);
        int lat;
        int lat_ok;
        wait_quiet();
        eng_mode = mode;
        eng_lat = 2;
        if (port) begin p1_addr = rand_addr(); p1_write = 1'b0; p1_req = 1'b1; end
        else begin p0_addr = rand_addr(); p0_req = 1'b1; end
        lat = 0;
        while (!(p0_ack || p1_ack) && lat < 100) begin
            @(negedge clk); lat++;
            if (lat == 8 && mode == 2) begin
                vectors++; if (flash_en !== 1'b1) begin miscompares++; $display("FAIL stuck_launch got flash_en %b want 1", flash_en); end
            end
        end
        lat_ok = C_TO + 1;
        vectors++; if (lat != lat_ok) begin miscompares++; $display("FAIL to_latency got %0d want %0d", lat, lat_ok); end
        vectors++; if ((port ? p1_ack : p0_ack) !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL to_ack got ack %b%b err %b want own ack, err 1", p0_ack, p1_ack, err); end
        vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL to_rdata got %h want %h", rdata, exp_rdata); end
        last_port = port;
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clk);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL to_err_clear got %b want 0", err); end
        eng_mode = 0;
        test_latency();
    endtask

    task automatic test_reset_mid();
        logic [23:0] a;
        int b, st;
        bit acked;
        wait_quiet();
        eng_lat = 6;
        a = rand_addr() | 24'h000100;
        @(negedge clk);
        p1_addr = a; p1_write = 1'b0; p1_wdata = $urandom | 32'h1; p1_req = 1'b1;
        b = 0;
        while (!eng_busy && b < 20) begin @(negedge clk); b++; end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++; if ({flash_en, flash_write, p0_ack, p1_ack, err} !== 5'b0) begin miscompares++; $display("FAIL mid_rst_ctrl got %b want 00000", {flash_en, flash_write, p0_ack, p1_ack, err}); end
        vectors++; if (flash_addr !== 24'h0 || flash_data_in !== 32'h0 || rdata !== 32'h0) begin miscompares++; $display("FAIL mid_rst_data got %h/%h/%h want 0/0/0", flash_addr, flash_data_in, rdata); end
        acked = 1'b0;
        repeat (2) begin @(negedge clk); if (p0_ack || p1_ack) acked = 1'b1; end
        reset = 1'b0;
        last_port = 1;
        exp_rdata = 32'h0;
        st = eng_starts;
        b = 0;
        while (!(p0_ack || p1_ack) && b < 60) begin @(negedge clk); b++; end
        vectors++; if (acked || p1_ack !== 1'b1) begin miscompares++; $display("FAIL mid_rst_relaunch got ack_in_reset %b p1_ack %b want 0 1", acked, p1_ack); end
        vectors++; if (eng_starts != st + 1) begin miscompares++; $display("FAIL mid_rst_starts got %0d want %0d", eng_starts - st, 1); end
        exp_rdata = lookup(a[23:2]);
        vectors++; if (rdata !== exp_rdata || cap_addr !== {a[23:2], 2'b00}) begin miscompares++; $display("FAIL mid_rst_rdata got %h @%h want %h @%h", rdata, cap_addr, exp_rdata, {a[23:2], 2'b00}); end
        last_port = 1;
        p1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_read_deadbeef();
        test_write();
        test_back_to_back();
        test_random();
        test_timeout(1, 1'b0);
        test_timeout(2, 1'b1);
        test_reset_mid();
        run_reqs(2, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
